lsu_data_port: RTL
==================

Name: lsu_data_port

Overview:
- Load/store unit sitting directly upstream of data_mem in the Single-Cycle core's memory path.
- Accepts one load or store request at a time from the execute stage (RV32I funct3 encoding).
- Generates word address, byte enables and lane-aligned write data for data_mem.
- Returns sign- or zero-extended load data, or a misaligned/illegal fault, through a registered valid/ready response interface.

Parameters:
- ADDR_WIDTH, 32, width of request and memory address.
- MEM_LATENCY, 1, cycles from Mem_Read_Ctrl sampled high to Mem_Data_Read valid; legal range 1..4.

Ports:
- Clk_Core  in  1  core clock, all state on rising edge.
- Rst_Core  in  1  asynchronous, active-high reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  unit idle and able to accept.
- Req_Write  in  1  1 = store, 0 = load.
- Req_Funct3  in  3  RV32I width/sign code.
- Req_Address  in  ADDR_WIDTH  byte address.
- Req_Write_Data  in  32  store data, LSB-justified.
- Rsp_Valid  out  1  one-cycle response pulse.
- Rsp_Read_Data  out  32  extended load data; 0 for stores and faults.
- Rsp_Misaligned  out  1  valid with Rsp_Valid.
- Rsp_Illegal  out  1  valid with Rsp_Valid.
- Mem_Read_Ctrl  out  1  to data_mem Read_Ctrl.
- Mem_Write_Ctrl  out  4  to data_mem Write_Ctrl; bit k enables byte lane k.
- Mem_Data_Address  out  ADDR_WIDTH  to data_mem; bits [1:0] always 0.
- Mem_Data_Write  out  32  to data_mem.
- Mem_Data_Read  in  32  from data_mem.

Behaviour:
- Reset state: FSM IDLE, Req_Ready=1.
  - Rsp_Valid, Rsp_Misaligned and Rsp_Illegal = 0.
  - Rsp_Read_Data = 0.
  - All Mem_* outputs = 0.
- Reset mid-operation: in-flight request dropped, no response ever issued for it, outputs return to reset values immediately.
- All outputs are registered; there are no combinational paths from Req_* or Mem_Data_Read to outputs.
- States: IDLE, ACCESS, WAIT, RESP.
  - IDLE: Req_Ready=1. Handshake completes on a rising edge with Req_Valid&Req_Ready. The request is captured into internal registers, so Req_* is don't-care afterwards.
  - Decode at capture:
    - Illegal if load funct3 is in {011,110,111}, or store funct3 is in {011..111}. Illegal wins over misaligned.
    - Misaligned if halfword and addr[0]=1, or word and addr[1:0]!=0.
    - Any fault -> RESP directly with no memory access (no write, no read).
  - ACCESS (1 cycle):
    - Mem_Data_Address = {addr[ADDR_WIDTH-1:2],2'b00}.
    - Store, SB: Mem_Write_Ctrl = 4'b0001<<addr[1:0]; Mem_Data_Write = {4{data[7:0]}}.
    - Store, SH: Mem_Write_Ctrl = 4'b0011<<addr[1:0]; Mem_Data_Write = {2{data[15:0]}}.
    - Store, SW: Mem_Write_Ctrl = 4'b1111; Mem_Data_Write = data.
    - Store next state -> RESP.
    - Load: Mem_Read_Ctrl=1, Mem_Write_Ctrl=0, then -> WAIT.
  - WAIT (MEM_LATENCY cycles):
    - Mem_Read_Ctrl and Mem_Data_Address held.
    - On the last WAIT edge, Mem_Data_Read is captured and extracted:
      - shift right by 8*addr[1:0].
      - LB/LH sign-extend from bit 7/15.
      - LBU/LHU zero-extend.
      - LW unchanged.
    - Then -> RESP.
  - RESP (1 cycle): Rsp_Valid=1 with data/flags; Mem_* = 0; Req_Ready=0; then -> IDLE.
- Mem_* outputs are 0 in IDLE and RESP. Rsp_* are 0 outside RESP.
- Latency from the accepting edge to Rsp_Valid high:
  - Store: 2 cycles.
  - Load: 2+MEM_LATENCY cycles.
  - Fault: 1 cycle.
- Throughput: the next request is accepted no earlier than the edge after RESP.
- Req_Valid is ignored while Req_Ready=0; requests are never queued.
- Address bits above the memory range pass through unchanged; bounds are data_mem's concern.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF -> ACCESS has Mem_Write_Ctrl=1111, Mem_Data_Address=0x10; Rsp_Valid 2 cycles after accept; Rsp_Read_Data=0, no flags.
- Prior SW 0xDEADBEEF @0x10, then SB addr 0x13 data 0x000000A5 -> Mem_Write_Ctrl=1000, Mem_Data_Write=0xA5A5A5A5. LW @0x10 then returns 0xA5ADBEEF after 3 cycles.
- Word @0x20=0x80FF7F01 (via SW) -> load results:
  - LB @0x21 -> 0x0000007F
  - LB @0x22 -> 0xFFFFFFFF
  - LBU @0x23 -> 0x00000080
  - LH @0x22 -> 0xFFFF80FF
  - LHU @0x22 -> 0x000080FF
- LW @0x22 and SH @0x11 -> Rsp_Misaligned=1 one cycle after accept; no Mem_Read_Ctrl/Mem_Write_Ctrl pulse; memory unchanged. Load funct3=011 -> Rsp_Illegal=1, Rsp_Misaligned=0.
- Assert Rst_Core during WAIT of an LW -> Mem_Read_Ctrl drops asynchronously, no Rsp_Valid; Req_Ready=1 after release, and the next SW completes normally.
- Hold Req_Valid high for back-to-back SW then LW -> second accept occurs on the edge after the first RESP; Req_Ready low in ACCESS/WAIT/RESP; 200 random ops checked against a byte-masked reference model with MEM_LATENCY=1 and 3.

Source files
------------

// File: rtl/lsu_data_port.sv
// Load/store data port between the execute stage and data_mem.
// It accepts one RV32I load or store at a time, drives word-aligned memory
// accesses with byte-lane enables, and returns the extended load data or a
// fault flag as a one-cycle registered response.
module lsu_data_port #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  Clk_Core,
  input  logic                  Rst_Core,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic                  Req_Write,
  input  logic [2:0]            Req_Funct3,
  input  logic [ADDR_WIDTH-1:0] Req_Address,
  input  logic [31:0]           Req_Write_Data,
  output logic                  Rsp_Valid,
  output logic [31:0]           Rsp_Read_Data,
  output logic                  Rsp_Misaligned,
  output logic                  Rsp_Illegal,
  output logic                  Mem_Read_Ctrl,
  output logic [3:0]            Mem_Write_Ctrl,
  output logic [ADDR_WIDTH-1:0] Mem_Data_Address,
  output logic [31:0]           Mem_Data_Write,
  input  logic [31:0]           Mem_Data_Read
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  // WAIT runs MEM_LATENCY cycles, so the counter starts one below that.
  localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

  state_t                r_state;
  logic                  r_reqReady;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [1:0]            r_byteOff;
  logic [2:0]            r_waitCnt;
  logic                  r_rspValid;
  logic [31:0]           r_rspData;
  logic                  r_rspMis;
  logic                  r_rspIll;
  logic                  r_memRead;
  logic [3:0]            r_memWriteCtrl;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [31:0]           r_memWdata;

  logic                  w_illegal;
  logic                  w_misaligned;
  logic [3:0]            w_laneMask;
  logic [31:0]           w_laneData;
  logic [31:0]           w_shifted;
  logic [31:0]           w_loadData;

  // Fault classification is done on the raw request so the decision is
  // registered together with the handshake; illegal codes mask misalignment.
  assign w_illegal    = Req_Write ? (Req_Funct3 > 3'b010)
                                  : ((Req_Funct3 == 3'b011) || (Req_Funct3[2:1] == 2'b11));
  assign w_misaligned = ((Req_Funct3[1:0] == 2'b01) && Req_Address[0]) ||
                        ((Req_Funct3[1:0] == 2'b10) && (Req_Address[1:0] != 2'b00));

  // Store lane steering: replicate the datum across the word and enable
  // only the lanes that the byte offset selects.
  always_comb begin
    w_laneMask = 4'b1111;
    w_laneData = Req_Write_Data;
    case (Req_Funct3[1:0])
      2'b00: begin
        w_laneMask = 4'b0001 << Req_Address[1:0];
        w_laneData = {4{Req_Write_Data[7:0]}};
      end
      2'b01: begin
        w_laneMask = 4'b0011 << Req_Address[1:0];
        w_laneData = {2{Req_Write_Data[15:0]}};
      end
      default: begin
        w_laneMask = 4'b1111;
        w_laneData = Req_Write_Data;
      end
    endcase
  end

  assign w_shifted = Mem_Data_Read >> {r_byteOff, 3'b000};

  // Load extraction: bring the addressed bytes down to bit 0 and extend
  // according to the captured width/sign code.
  always_comb begin
    w_loadData = w_shifted;
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_loadData = {24'd0, w_shifted[7:0]};
      3'b101:  w_loadData = {16'd0, w_shifted[15:0]};
      default: w_loadData = w_shifted;
    endcase
  end

  // Request sequencer: every output is a register written on the edge that
  // enters the state in which it must be visible.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      r_state        <= S_IDLE;
      r_reqReady     <= 1'b1;
      r_write        <= 1'b0;
      r_funct3       <= 3'd0;
      r_byteOff      <= 2'd0;
      r_waitCnt      <= 3'd0;
      r_rspValid     <= 1'b0;
      r_rspData      <= 32'd0;
      r_rspMis       <= 1'b0;
      r_rspIll       <= 1'b0;
      r_memRead      <= 1'b0;
      r_memWriteCtrl <= 4'd0;
      r_memAddr      <= '0;
      r_memWdata     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Req_Valid) begin
            r_reqReady <= 1'b0;
            r_write    <= Req_Write;
            r_funct3   <= Req_Funct3;
            r_byteOff  <= Req_Address[1:0];
            if (w_illegal || w_misaligned) begin
              r_state    <= S_RESP;
              r_rspValid <= 1'b1;
              r_rspData  <= 32'd0;
              r_rspIll   <= w_illegal;
              r_rspMis   <= w_misaligned && !w_illegal;
            end else begin
              r_state   <= S_ACCESS;
              r_memAddr <= {Req_Address[ADDR_WIDTH-1:2], 2'b00};
              if (Req_Write) begin
                r_memWriteCtrl <= w_laneMask;
                r_memWdata     <= w_laneData;
              end else begin
                r_memRead <= 1'b1;
              end
            end
          end
        end
        S_ACCESS: begin
          if (r_write) begin
            r_state        <= S_RESP;
            r_memWriteCtrl <= 4'd0;
            r_memWdata     <= 32'd0;
            r_memAddr      <= '0;
            r_rspValid     <= 1'b1;
            r_rspData      <= 32'd0;
          end else begin
            r_state   <= S_WAIT;
            r_waitCnt <= LAT_LAST;
          end
        end
        S_WAIT: begin
          if (r_waitCnt == 3'd0) begin
            r_state    <= S_RESP;
            r_memRead  <= 1'b0;
            r_memAddr  <= '0;
            r_rspValid <= 1'b1;
            r_rspData  <= w_loadData;
          end else begin
            r_waitCnt <= r_waitCnt - 3'd1;
          end
        end
        S_RESP: begin
          r_state    <= S_IDLE;
          r_reqReady <= 1'b1;
          r_rspValid <= 1'b0;
          r_rspData  <= 32'd0;
          r_rspMis   <= 1'b0;
          r_rspIll   <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_reqReady <= 1'b1;
        end
      endcase
    end
  end

  assign Req_Ready        = r_reqReady;
  assign Rsp_Valid        = r_rspValid;
  assign Rsp_Read_Data    = r_rspData;
  assign Rsp_Misaligned   = r_rspMis;
  assign Rsp_Illegal      = r_rspIll;
  assign Mem_Read_Ctrl    = r_memRead;
  assign Mem_Write_Ctrl   = r_memWriteCtrl;
  assign Mem_Data_Address = r_memAddr;
  assign Mem_Data_Write   = r_memWdata;

endmodule
